// File: rtl/multiword_add_seq.sv
// multiword_add_seq: serial W-bit adder built from a single 4-bit ripple slice.
// One nibble is processed per clock, LSB nibble first, with a 1-bit carry
// register linking consecutive nibbles.
//
// Optional feature macro: MWADD_SUB_EN
//   defined   -> adds the 'sub' port; sub=1 computes a + ~b + 1 (cin ignored),
//                cout=1 then means "no borrow".
//   undefined -> addition only, same timing.
//
// state | meaning
// IDLE  | waiting for start; sum/cout hold the last result
// RUN   | one nibble per cycle through the slice, busy=1

module multiword_add_seq #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
`ifdef MWADD_SUB_EN
  input  logic         sub,
`endif
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [IDX_W+1:0]   nib_base;
  logic [3:0]         a_nib;
  logic [3:0]         b_nib;
  logic [4:0]         slice_res;
  logic               last_nib;

  // The single 4-bit ripple slice, fed by the nibble selected by the index.
  always_comb begin
    nib_base  = {idx_q, 2'b00};
    a_nib     = a_q[nib_base +: 4];
    b_nib     = b_q[nib_base +: 4];
    slice_res = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    last_nib  = (idx_q == IDX_W'(NIBBLES - 1));
  end

  // Next-state and datapath update for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a;
`ifdef MWADD_SUB_EN
          // Subtraction is two's complement: invert B and force carry-in to 1.
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end else begin
            b_d     = b;
            carry_d = cin;
          end
`else
          b_d     = b;
          carry_d = cin;
`endif
          idx_d   = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        sum_d[nib_base +: 4] = slice_res[3:0];
        carry_d              = slice_res[4];
        idx_d                = idx_q + IDX_W'(1);
        if (last_nib) begin
          cout_d  = slice_res[4];
          idx_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq with NIBBLES=4.
// Subtraction scenarios are compiled in only when MWADD_SUB_EN is defined.

module tb_multiword_add_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_fail   = 0;

  multiword_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef MWADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // Drive a start pulse; returns 1 time unit after the accepting edge E0.
  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = ci;
    sub   = sb;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b need 0", done); end
    n_checks++;
    if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum: got %h need 0000", sum); end
    n_checks++;
    if (cout !== 1'b0) begin n_fail++; $display("FAIL reset_cout: got %b need 0", cout); end
  endtask

  task automatic test_carry_chain;
    launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    // Now just after E0: busy must be high for edges E0..E0+3.
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL chain_busy_%0d: got busy=%b done=%b need busy=1 done=0", k, busy, done);
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_done: got busy=%b done=%b need busy=0 done=1", busy, done);
    end
    n_checks++;
    if (sum !== 16'h0000 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_result: got sum=%h cout=%b need sum=0000 cout=1", sum, cout);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL chain_hold: got done=%b sum=%h cout=%b need done=0 sum=0000 cout=1",
               done, sum, cout);
    end
  endtask

  task automatic test_back_to_back;
    launch(16'h1234, 16'h4321, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h5556 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: got done=%b sum=%h cout=%b need done=1 sum=5556 cout=0",
               done, sum, cout);
    end
    // Start issued in the done cycle.
    start = 1'b1;
    a     = 16'h8000;
    b     = 16'h8000;
    cin   = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b need busy=1 done=0", busy, done);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got done=%b need 0", done); end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second: got done=%b sum=%h cout=%b need done=1 sum=0000 cout=1",
               done, sum, cout);
    end
  endtask

  task automatic test_ignore_start;
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    a     = 16'hAAAA;
    b     = 16'h5555;
    cin   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy: got %b need 1", busy); end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h0100 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_result: got done=%b sum=%h cout=%b need done=1 sum=0100 cout=0",
               done, sum, cout);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_idle: got busy=%b done=%b need busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_wrap_max;
    logic seen_done;
    launch(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    seen_done = 1'b0;
    for (int k = 0; k < 4 && !seen_done; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done !== 1'b1 || sum !== 16'hFFFF || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_max: got done_seen=%b sum=%h cout=%b need done_seen=1 sum=FFFF cout=1",
               seen_done, sum, cout);
    end
  endtask

  task automatic test_reset_mid_run;
    logic saw_done;
    launch(16'h1234, 16'h1111, 1'b0, 1'b0);
    #0;
    // Just after E0; assert rst so it is sampled at edge E0+2.
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrun_outputs: got busy=%b done=%b sum=%h cout=%b need all 0",
               busy, done, sum, cout);
    end
    saw_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrun_no_done: got done pulse=%b need 0", saw_done);
    end
    // Reset takes priority over a simultaneous start.
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h00F1;
    cin   = 1'b0;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_priority: got busy=%b need 0", busy); end
    launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h1000 || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL rstrun_recover: got done=%b sum=%h cout=%b need done=1 sum=1000 cout=0",
               done, sum, cout);
    end
  endtask

`ifdef MWADD_SUB_EN
  task automatic test_subtract;
    launch(16'h0005, 16'h0007, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'hFFFE || cout !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_borrow: got done=%b sum=%h cout=%b need done=1 sum=FFFE cout=0",
               done, sum, cout);
    end
    launch(16'h0007, 16'h0005, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || sum !== 16'h0002 || cout !== 1'b1) begin
      n_fail++;
      $display("FAIL sub_noborrow: got done=%b sum=%h cout=%b need done=1 sum=0002 cout=1",
               done, sum, cout);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    test_reset();
    test_carry_chain();
    test_back_to_back();
    test_ignore_start();
    test_wrap_max();
    test_reset_mid_run();
`ifdef MWADD_SUB_EN
    test_subtract();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter: NIBBLES, 4, number of 4-bit slices per operand; W = 4*NIBBLES; legal range 2..16.
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: start  input  1  request a new addition; sampled only when busy=0.
REQ-005 SHALL have port: a  input  W  operand A, captured at accepted start.
REQ-006 SHALL have port: b  input  W  operand B, captured at accepted start.
REQ-007 SHALL have port: cin  input  1  carry-in to nibble 0, captured at accepted start.
REQ-008 SHALL have port: sub  input  1  subtract select, captured at accepted start; present only with MWADD_SUB_EN.
REQ-009 SHALL have port: busy  output  1  high while slices are being processed.
REQ-010 SHALL have port: done  output  1  single-cycle pulse, result valid.
REQ-011 SHALL have port: sum  output  W  result word.
REQ-012 SHALL have port: cout  output  1  carry out of the top nibble.

Function
REQ-013 SHALL compute a+b+cin using exactly one 4-bit ripple-carry slice, processing one nibble per cycle, LSB nibble first.
REQ-014 SHALL implement an FSM with states IDLE and RUN; a nibble index counter 0..NIBBLES-1; a 1-bit carry register between nibbles.
REQ-015 SHALL accept start only when busy=0 (IDLE), which includes the done cycle; on the accepting edge E0: capture a, b, cin (and sub); clear the index; enter RUN; set busy=1.
REQ-016 SHALL, in RUN, at edge E0+1+i, write slice result to sum[4i+3:4i], load the carry register with the slice carry, and increment the index.
REQ-017 SHALL, at edge E0+NIBBLES (last nibble), set cout to the final slice carry, return to IDLE, clear busy, and assert done for exactly one cycle.
REQ-018 SHALL hold busy high for exactly NIBBLES cycles, with done and busy never high in the same cycle.
REQ-019 SHALL ignore start while busy=1: no recapture and no effect on the operation in flight.
REQ-020 SHALL leave sum bits of unprocessed nibbles unspecified while busy=1, and SHALL hold sum and cout stable from done until the next accepted start.
REQ-021 SHALL, for start in the done cycle, accept it with the same timing as from IDLE (back-to-back throughput of one result per NIBBLES+1 cycles).
REQ-022 SHALL wrap the sum modulo 2^W, with the overflowed bit reported only on cout.

Reset
REQ-023 SHALL, with rst=1 at a rising edge, force IDLE, index=0, carry register=0, busy=0, done=0, sum=0, cout=0.
REQ-024 SHALL, on rst asserted mid-RUN, abandon the operation with no done pulse; rst SHALL take priority over a simultaneous start.

Configuration
REQ-025 SHALL, with macro MWADD_SUB_EN defined, provide the sub port; sub=1 SHALL compute a + ~b + 1 (cin ignored), with cout=1 meaning no borrow.
REQ-026 SHALL, without MWADD_SUB_EN, omit the sub port and perform addition only, with identical timing.

Verification (NIBBLES=4)
REQ-027 SHALL verify: reset then idle -> busy=0, done=0, sum=0x0000, cout=0.
REQ-028 SHALL verify: start with a=0xFFFF, b=0x0001, cin=0 -> busy high 4 cycles, done pulse on the 4th edge after start, sum=0x0000, cout=1.
REQ-029 SHALL verify: start with a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; then start re-issued in the done cycle with a=0x8000, b=0x8000 -> sum=0x0000, cout=1, 5 cycles later.
REQ-030 SHALL verify: start with a=0x00FF, b=0x0001; start pulsed again with a=0xAAAA at edge 2 -> ignored, sum=0x0100, cout=0.
REQ-031 SHALL verify: rst asserted at edge 2 of RUN -> no done pulse, all outputs 0, next start completes normally.
REQ-032 SHALL verify, with MWADD_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; and a=0x0007, b=0x0005 -> sum=0x0002, cout=1.
